// File: rtl/regfile_scoreboard_if.sv
// regfile_scoreboard_if
//   Bundles the issue-side (reads, scoreboard set, clear request) and the
//   writeback-side (two write ports) signals of one register bank.
//   master : issue/writeback logic driving addresses, write data and requests.
//   slave  : the register bank returning read data, pending flags and status.
interface regfile_scoreboard_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic              rd_pend_a;
  logic              rd_pend_b;
  logic              wr0_en;
  logic [ADDR_W-1:0] wr0_addr;
  logic [DATA_W-1:0] wr0_data;
  logic              wr1_en;
  logic [ADDR_W-1:0] wr1_addr;
  logic [DATA_W-1:0] wr1_data;
  logic              sb_set_en;
  logic [ADDR_W-1:0] sb_set_addr;
  logic              clr_req;
  logic              clr_busy;
  logic              any_pend;

  modport master (
    output rd_addr_a, rd_addr_b, wr0_en, wr0_addr, wr0_data,
           wr1_en, wr1_addr, wr1_data, sb_set_en, sb_set_addr, clr_req,
    input  rd_data_a, rd_data_b, rd_pend_a, rd_pend_b, clr_busy, any_pend
  );

  modport slave (
    input  rd_addr_a, rd_addr_b, wr0_en, wr0_addr, wr0_data,
           wr1_en, wr1_addr, wr1_data, sb_set_en, sb_set_addr, clr_req,
    output rd_data_a, rd_data_b, rd_pend_a, rd_pend_b, clr_busy, any_pend
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Generic register bank with two read ports, two write ports, a per-register
//   pending scoreboard and a sequenced clear sweep. Instantiated as the GPR
//   bank (ZERO_REG=1) and as the FPR bank (ZERO_REG=0).
// Ports:
//   clk    : clock, all state updates on the rising edge
//   reset  : asynchronous active-high reset
//   bus    : slave side of regfile_scoreboard_if
//            rd_addr_a/b -> rd_data_a/b, rd_pend_a/b (combinational)
//            wr0_*, wr1_* : writeback ports (wr1 wins on collision)
//            sb_set_*     : mark a register pending at issue
//            clr_req      : start clear sweep; clr_busy while sweeping
//            any_pend     : OR of all registered pending bits
module regfile_scoreboard #(
  parameter int              DATA_W   = 32,
  parameter int              NUM_REGS = 32,
  parameter int              ADDR_W   = 5,
  parameter bit              ZERO_REG = 1'b1,
  parameter bit              BYPASS   = 1'b1,
  parameter int              SP_IDX   = 29,
  parameter logic [DATA_W-1:0] SP_INIT = 32'h80000000,
  parameter int              GP_IDX   = 28,
  parameter logic [DATA_W-1:0] GP_INIT = 32'h10008000
) (
  input logic                clk,
  input logic                reset,
  regfile_scoreboard_if.slave bus
);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] pend_q, pend_d;

  function automatic logic [DATA_W-1:0] init_val(input int idx);
    if (idx == SP_IDX) return SP_INIT;
    if (idx == GP_IDX) return GP_INIT;
    return '0;
  endfunction

  // Hard-wired zero register: reads 0, ignores writes and scoreboard sets.
  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return ZERO_REG && (a == '0);
  endfunction

  // ---------------------------------------------------------------------------
  // Next state: writes/scoreboard only in IDLE, sweep owns the array otherwise
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    regs_d  = regs_q;
    pend_d  = pend_q;
    case (state_q)
      IDLE: begin
        if (bus.wr0_en && !is_zero(bus.wr0_addr)) begin
          regs_d[bus.wr0_addr] = bus.wr0_data;
          pend_d[bus.wr0_addr] = 1'b0;
        end
        // wr1 applied after wr0 so it wins an address collision
        if (bus.wr1_en && !is_zero(bus.wr1_addr)) begin
          regs_d[bus.wr1_addr] = bus.wr1_data;
          pend_d[bus.wr1_addr] = 1'b0;
        end
        // set after the clears: a newly issued producer supersedes the
        // result retiring in the same cycle
        if (bus.sb_set_en && !is_zero(bus.sb_set_addr))
          pend_d[bus.sb_set_addr] = 1'b1;
        if (bus.clr_req) begin
          state_d = SWEEP;
          ptr_d   = '0;
        end
      end
      SWEEP: begin
        regs_d[ptr_q] = init_val(int'(ptr_q));
        pend_d[ptr_q] = 1'b0;
        ptr_d         = ptr_q + 1'b1;
        if (ptr_q == ADDR_W'(NUM_REGS - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      pend_q  <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= init_val(i);
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      pend_q  <= pend_d;
      regs_q  <= regs_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports (index 0 = A, 1 = B)
  // ---------------------------------------------------------------------------
  logic [1:0][ADDR_W-1:0] rd_addr;
  logic [1:0][DATA_W-1:0] rd_data;
  logic [1:0]             rd_pend;

  assign rd_addr = {bus.rd_addr_b, bus.rd_addr_a};

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic hit0, hit1;
    // forwarding is suppressed during the sweep because writes are dropped
    assign hit0 = BYPASS && (state_q == IDLE) && bus.wr0_en && (bus.wr0_addr == rd_addr[p]);
    assign hit1 = BYPASS && (state_q == IDLE) && bus.wr1_en && (bus.wr1_addr == rd_addr[p]);
    assign rd_data[p] = is_zero(rd_addr[p]) ? '0          :
                        hit1                ? bus.wr1_data :
                        hit0                ? bus.wr0_data :
                                              regs_q[rd_addr[p]];
    assign rd_pend[p] = !is_zero(rd_addr[p]) && !hit0 && !hit1 && pend_q[rd_addr[p]];
  end

  assign bus.rd_data_a = rd_data[0];
  assign bus.rd_data_b = rd_data[1];
  assign bus.rd_pend_a = rd_pend[0];
  assign bus.rd_pend_b = rd_pend[1];
  assign bus.clr_busy  = (state_q == SWEEP);
  assign bus.any_pend  = |pend_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;
  localparam int DW = 32;
  localparam int NR = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  regfile_scoreboard_if #(.DATA_W(DW), .ADDR_W(AW)) g ();
  regfile_scoreboard_if #(.DATA_W(DW), .ADDR_W(AW)) f ();

  regfile_scoreboard #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW)) u_gpr (
    .clk(clk), .reset(reset), .bus(g));

  regfile_scoreboard #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW),
                       .ZERO_REG(1'b0), .BYPASS(1'b0)) u_fpr (
    .clk(clk), .reset(reset), .bus(f));

  // Reference model of the GPR bank: architectural contents, pending flags and
  // the number of sweep writes still to come.
  logic [DW-1:0] m_reg  [NR];
  logic          m_pend [NR];
  int            m_left;
  int            m_idx;

  function automatic logic [DW-1:0] init_of(input int i);
    if (i == 29) return 32'h80000000;
    if (i == 28) return 32'h10008000;
    return '0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_reg[i]  = init_of(i);
      m_pend[i] = 1'b0;
    end
    m_left = 0;
    m_idx  = 0;
  endtask

  task automatic model_step();
    if (m_left > 0) begin
      m_reg[m_idx]  = init_of(m_idx);
      m_pend[m_idx] = 1'b0;
      m_idx++;
      m_left--;
    end else begin
      if (g.wr0_en && g.wr0_addr != 0) begin
        m_reg[g.wr0_addr] = g.wr0_data; m_pend[g.wr0_addr] = 1'b0;
      end
      if (g.wr1_en && g.wr1_addr != 0) begin
        m_reg[g.wr1_addr] = g.wr1_data; m_pend[g.wr1_addr] = 1'b0;
      end
      if (g.sb_set_en && g.sb_set_addr != 0) m_pend[g.sb_set_addr] = 1'b1;
      if (g.clr_req) begin m_left = NR; m_idx = 0; end
    end
  endtask

  function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (m_left == 0 && g.wr1_en && g.wr1_addr == a) return g.wr1_data;
    if (m_left == 0 && g.wr0_en && g.wr0_addr == a) return g.wr0_data;
    return m_reg[a];
  endfunction

  function automatic logic exp_pend(input logic [AW-1:0] a);
    if (a == 0) return 1'b0;
    if (m_left == 0 && ((g.wr1_en && g.wr1_addr == a) || (g.wr0_en && g.wr0_addr == a)))
      return 1'b0;
    return m_pend[a];
  endfunction

  function automatic logic exp_any();
    logic r = 1'b0;
    for (int i = 0; i < NR; i++) r |= m_pend[i];
    return r;
  endfunction

  task automatic idle_g();
    g.rd_addr_a = '0; g.rd_addr_b = '0;
    g.wr0_en = 1'b0; g.wr0_addr = '0; g.wr0_data = '0;
    g.wr1_en = 1'b0; g.wr1_addr = '0; g.wr1_data = '0;
    g.sb_set_en = 1'b0; g.sb_set_addr = '0; g.clr_req = 1'b0;
  endtask

  task automatic idle_f();
    f.rd_addr_a = '0; f.rd_addr_b = '0;
    f.wr0_en = 1'b0; f.wr0_addr = '0; f.wr0_data = '0;
    f.wr1_en = 1'b0; f.wr1_addr = '0; f.wr1_data = '0;
    f.sb_set_en = 1'b0; f.sb_set_addr = '0; f.clr_req = 1'b0;
  endtask

  // advance one clock: update the model with the inputs seen at this edge
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr0(input logic [AW-1:0] a, input logic [DW-1:0] d);
    g.wr0_en = 1'b1; g.wr0_addr = a; g.wr0_data = d;
  endtask

  task automatic test_reset();
    wr0(3, 32'hCAFE); g.sb_set_en = 1'b1; g.sb_set_addr = 4;
    tick(); idle_g();
    #3; reset = 1'b1; model_reset(); #1;
    n_tests++; if (g.clr_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", g.clr_busy); end
    n_tests++; if (g.any_pend !== 1'b0) begin n_fail++; $display("FAIL reset_any_pend: got %b want 0", g.any_pend); end
    for (int a = 0; a < NR; a++) begin
      g.rd_addr_a = AW'(a); g.rd_addr_b = AW'(NR - 1 - a); #1;
      n_tests++; if (g.rd_data_a !== init_of(a)) begin n_fail++; $display("FAIL reset_data_a[%0d]: got %h want %h", a, g.rd_data_a, init_of(a)); end
      n_tests++; if (g.rd_data_b !== init_of(NR - 1 - a)) begin n_fail++; $display("FAIL reset_data_b[%0d]: got %h want %h", NR - 1 - a, g.rd_data_b, init_of(NR - 1 - a)); end
      n_tests++; if (g.rd_pend_a !== 1'b0) begin n_fail++; $display("FAIL reset_pend_a[%0d]: got %b want 0", a, g.rd_pend_a); end
    end
    g.rd_addr_a = 29; g.rd_addr_b = 28; #1;
    n_tests++; if (g.rd_data_a !== 32'h80000000) begin n_fail++; $display("FAIL reset_sp: got %h want 80000000", g.rd_data_a); end
    n_tests++; if (g.rd_data_b !== 32'h10008000) begin n_fail++; $display("FAIL reset_gp: got %h want 10008000", g.rd_data_b); end
    idle_g();
    @(negedge clk); reset = 1'b0;
    tick();
  endtask

  task automatic test_dual_write();
    wr0(5, 32'hAAAA0000); g.wr1_en = 1'b1; g.wr1_addr = 5; g.wr1_data = 32'h5555FFFF;
    g.rd_addr_a = 5; #1;
    n_tests++; if (g.rd_data_a !== 32'h5555FFFF) begin n_fail++; $display("FAIL collide_bypass: got %h want 5555ffff", g.rd_data_a); end
    tick(); idle_g(); g.rd_addr_a = 5; #1;
    n_tests++; if (g.rd_data_a !== 32'h5555FFFF) begin n_fail++; $display("FAIL collide_commit: got %h want 5555ffff", g.rd_data_a); end
    wr0(0, 32'hDEADBEEF); g.rd_addr_a = 0; #1;
    n_tests++; if (g.rd_data_a !== 32'h0) begin n_fail++; $display("FAIL zero_bypass: got %h want 0", g.rd_data_a); end
    tick(); idle_g(); g.rd_addr_a = 0; #1;
    n_tests++; if (g.rd_data_a !== 32'h0) begin n_fail++; $display("FAIL zero_commit: got %h want 0", g.rd_data_a); end
    wr0(10, 32'h0A0A0A0A); g.wr1_en = 1'b1; g.wr1_addr = 11; g.wr1_data = 32'h0B0B0B0B;
    tick(); idle_g(); g.rd_addr_a = 10; g.rd_addr_b = 11; #1;
    n_tests++; if (g.rd_data_a !== 32'h0A0A0A0A) begin n_fail++; $display("FAIL dual_wr0: got %h want 0a0a0a0a", g.rd_data_a); end
    n_tests++; if (g.rd_data_b !== 32'h0B0B0B0B) begin n_fail++; $display("FAIL dual_wr1: got %h want 0b0b0b0b", g.rd_data_b); end
  endtask

  task automatic test_scoreboard();
    idle_g(); g.sb_set_en = 1'b1; g.sb_set_addr = 7;
    tick(); idle_g(); g.rd_addr_a = 7; #1;
    n_tests++; if (g.rd_pend_a !== 1'b1) begin n_fail++; $display("FAIL sb_set_pend: got %b want 1", g.rd_pend_a); end
    n_tests++; if (g.any_pend !== 1'b1) begin n_fail++; $display("FAIL sb_set_any: got %b want 1", g.any_pend); end
    g.wr1_en = 1'b1; g.wr1_addr = 7; g.wr1_data = 32'h3F800000; #1;
    n_tests++; if (g.rd_pend_a !== 1'b0) begin n_fail++; $display("FAIL sb_bypass_pend: got %b want 0", g.rd_pend_a); end
    n_tests++; if (g.rd_data_a !== 32'h3F800000) begin n_fail++; $display("FAIL sb_bypass_data: got %h want 3f800000", g.rd_data_a); end
    tick(); idle_g(); g.rd_addr_a = 7; #1;
    n_tests++; if (g.rd_pend_a !== 1'b0) begin n_fail++; $display("FAIL sb_clear_pend: got %b want 0", g.rd_pend_a); end
    n_tests++; if (g.any_pend !== 1'b0) begin n_fail++; $display("FAIL sb_clear_any: got %b want 0", g.any_pend); end
    wr0(9, 32'h00000099); g.sb_set_en = 1'b1; g.sb_set_addr = 9;
    tick(); idle_g(); g.rd_addr_b = 9; #1;
    n_tests++; if (g.rd_pend_b !== 1'b1) begin n_fail++; $display("FAIL sb_set_wins: got %b want 1", g.rd_pend_b); end
    n_tests++; if (g.rd_data_b !== 32'h00000099) begin n_fail++; $display("FAIL sb_set_wins_data: got %h want 99", g.rd_data_b); end
    wr0(9, 32'h0); tick(); idle_g();
    g.sb_set_en = 1'b1; g.sb_set_addr = 0;
    tick(); idle_g(); g.rd_addr_a = 0; #1;
    n_tests++; if (g.any_pend !== 1'b0) begin n_fail++; $display("FAIL sb_zero_any: got %b want 0", g.any_pend); end
    n_tests++; if (g.rd_pend_a !== 1'b0) begin n_fail++; $display("FAIL sb_zero_pend: got %b want 0", g.rd_pend_a); end
  endtask

  // run a sweep window, checking busy and two read ports against the model
  task automatic sweep_window(input string tag, input logic [AW-1:0] watch, input bit inject);
    int busy = 0;
    for (int c = 0; c < NR + 2; c++) begin
      if (inject && c == 5) g.clr_req = 1'b1;
      if (inject && c == 10) begin wr0(3, 32'h1); g.sb_set_en = 1'b1; g.sb_set_addr = 2; end
      g.rd_addr_a = watch; g.rd_addr_b = AW'(c); #1;
      if (g.clr_busy === 1'b1) busy++;
      n_tests++; if (g.clr_busy !== (m_left > 0)) begin n_fail++; $display("FAIL %s_busy[%0d]: got %b want %b", tag, c, g.clr_busy, m_left > 0); end
      n_tests++; if (g.rd_data_a !== exp_data(watch)) begin n_fail++; $display("FAIL %s_data_a[%0d]: got %h want %h", tag, c, g.rd_data_a, exp_data(watch)); end
      n_tests++; if (g.rd_data_b !== exp_data(AW'(c))) begin n_fail++; $display("FAIL %s_data_b[%0d]: got %h want %h", tag, c, g.rd_data_b, exp_data(AW'(c))); end
      tick(); idle_g();
    end
    n_tests++; if (busy !== NR) begin n_fail++; $display("FAIL %s_busy_len: got %0d want %0d", tag, busy, NR); end
  endtask

  task automatic test_clear_sweep();
    for (int a = 1; a < NR; a++) begin wr0(AW'(a), DW'(a)); tick(); end
    idle_g(); g.sb_set_en = 1'b1; g.sb_set_addr = 20; tick(); idle_g(); #1;
    n_tests++; if (g.any_pend !== 1'b1) begin n_fail++; $display("FAIL pre_sweep_any: got %b want 1", g.any_pend); end
    g.clr_req = 1'b1; tick(); idle_g();
    sweep_window("sweep", 3, 1'b1);
    for (int a = 0; a < NR; a++) begin
      g.rd_addr_a = AW'(a); #1;
      n_tests++; if (g.rd_data_a !== init_of(a)) begin n_fail++; $display("FAIL post_sweep[%0d]: got %h want %h", a, g.rd_data_a, init_of(a)); end
    end
    n_tests++; if (g.any_pend !== 1'b0) begin n_fail++; $display("FAIL post_sweep_any: got %b want 0", g.any_pend); end
    idle_g();
  endtask

  task automatic test_reset_during_sweep();
    wr0(1, 32'h11111111); tick();
    wr0(29, 32'hFFFF0000); tick();
    idle_g(); g.sb_set_en = 1'b1; g.sb_set_addr = 6; tick();
    idle_g(); g.clr_req = 1'b1; tick(); idle_g();
    for (int c = 0; c < 10; c++) tick();
    n_tests++; if (g.clr_busy !== 1'b1) begin n_fail++; $display("FAIL mid_sweep_busy: got %b want 1", g.clr_busy); end
    #3; reset = 1'b1; model_reset(); #1;
    n_tests++; if (g.clr_busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", g.clr_busy); end
    n_tests++; if (g.any_pend !== 1'b0) begin n_fail++; $display("FAIL abort_any: got %b want 0", g.any_pend); end
    g.rd_addr_a = 29; g.rd_addr_b = 28; #1;
    n_tests++; if (g.rd_data_a !== 32'h80000000) begin n_fail++; $display("FAIL abort_sp: got %h want 80000000", g.rd_data_a); end
    n_tests++; if (g.rd_data_b !== 32'h10008000) begin n_fail++; $display("FAIL abort_gp: got %h want 10008000", g.rd_data_b); end
    g.rd_addr_a = 1; #1;
    n_tests++; if (g.rd_data_a !== 32'h0) begin n_fail++; $display("FAIL abort_r1: got %h want 0", g.rd_data_a); end
    idle_g();
    @(negedge clk); reset = 1'b0;
    tick();
    n_tests++; if (g.clr_busy !== 1'b0) begin n_fail++; $display("FAIL after_abort_busy: got %b want 0", g.clr_busy); end
    wr0(12, 32'h0000C0DE); g.rd_addr_a = 12; #1;
    n_tests++; if (g.rd_data_a !== 32'h0000C0DE) begin n_fail++; $display("FAIL after_abort_bypass: got %h want c0de", g.rd_data_a); end
    tick(); idle_g(); g.rd_addr_a = 12; #1;
    n_tests++; if (g.rd_data_a !== 32'h0000C0DE) begin n_fail++; $display("FAIL after_abort_write: got %h want c0de", g.rd_data_a); end
    // a fresh sweep must start from register 0 and last the full length
    wr0(1, 32'h00001234); tick(); idle_g();
    g.clr_req = 1'b1; tick(); idle_g();
    sweep_window("resweep", 1, 1'b0);
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      g.wr0_en      = 1'($urandom_range(0, 1));
      g.wr0_addr    = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      g.wr0_data    = $urandom;
      g.wr1_en      = 1'($urandom_range(0, 1));
      g.wr1_addr    = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      g.wr1_data    = $urandom;
      g.sb_set_en   = ($urandom_range(0, 2) == 0);
      g.sb_set_addr = AW'($urandom_range(0, 7));
      g.clr_req     = ($urandom_range(0, 79) == 0);
      g.rd_addr_a   = AW'($urandom_range(0, 7));
      g.rd_addr_b   = ($urandom_range(0, 1) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      #1;
      n_tests++; if (g.rd_data_a !== exp_data(g.rd_addr_a)) begin n_fail++; $display("FAIL rnd_data_a[%0d]: got %h want %h", c, g.rd_data_a, exp_data(g.rd_addr_a)); end
      n_tests++; if (g.rd_data_b !== exp_data(g.rd_addr_b)) begin n_fail++; $display("FAIL rnd_data_b[%0d]: got %h want %h", c, g.rd_data_b, exp_data(g.rd_addr_b)); end
      n_tests++; if (g.rd_pend_a !== exp_pend(g.rd_addr_a)) begin n_fail++; $display("FAIL rnd_pend_a[%0d]: got %b want %b", c, g.rd_pend_a, exp_pend(g.rd_addr_a)); end
      n_tests++; if (g.rd_pend_b !== exp_pend(g.rd_addr_b)) begin n_fail++; $display("FAIL rnd_pend_b[%0d]: got %b want %b", c, g.rd_pend_b, exp_pend(g.rd_addr_b)); end
      n_tests++; if (g.clr_busy !== (m_left > 0)) begin n_fail++; $display("FAIL rnd_busy[%0d]: got %b want %b", c, g.clr_busy, m_left > 0); end
      n_tests++; if (g.any_pend !== exp_any()) begin n_fail++; $display("FAIL rnd_any[%0d]: got %b want %b", c, g.any_pend, exp_any()); end
      tick();
    end
    idle_g();
  endtask

  task automatic test_fpr();
    idle_g(); idle_f();
    f.wr0_en = 1'b1; f.wr0_addr = 0; f.wr0_data = 32'h12345678; f.rd_addr_a = 0; #1;
    n_tests++; if (f.rd_data_a !== 32'h0) begin n_fail++; $display("FAIL fpr_no_bypass: got %h want 0", f.rd_data_a); end
    tick(); idle_f(); f.rd_addr_a = 0; f.rd_addr_b = 29; #1;
    n_tests++; if (f.rd_data_a !== 32'h12345678) begin n_fail++; $display("FAIL fpr_r0_write: got %h want 12345678", f.rd_data_a); end
    n_tests++; if (f.rd_data_b !== 32'h80000000) begin n_fail++; $display("FAIL fpr_sp: got %h want 80000000", f.rd_data_b); end
    f.sb_set_en = 1'b1; f.sb_set_addr = 0;
    tick(); idle_f(); f.rd_addr_a = 0; #1;
    n_tests++; if (f.rd_pend_a !== 1'b1) begin n_fail++; $display("FAIL fpr_r0_pend: got %b want 1", f.rd_pend_a); end
    n_tests++; if (f.any_pend !== 1'b1) begin n_fail++; $display("FAIL fpr_any: got %b want 1", f.any_pend); end
    f.wr1_en = 1'b1; f.wr1_addr = 0; f.wr1_data = 32'hAABBCCDD; #1;
    n_tests++; if (f.rd_pend_a !== 1'b1) begin n_fail++; $display("FAIL fpr_pend_no_bypass: got %b want 1", f.rd_pend_a); end
    n_tests++; if (f.rd_data_a !== 32'h12345678) begin n_fail++; $display("FAIL fpr_data_no_bypass: got %h want 12345678", f.rd_data_a); end
    tick(); idle_f(); f.rd_addr_a = 0; #1;
    n_tests++; if (f.rd_pend_a !== 1'b0) begin n_fail++; $display("FAIL fpr_pend_clear: got %b want 0", f.rd_pend_a); end
    n_tests++; if (f.rd_data_a !== 32'hAABBCCDD) begin n_fail++; $display("FAIL fpr_wr1: got %h want aabbccdd", f.rd_data_a); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    idle_g(); idle_f(); model_reset();
    reset = 1'b1;
    #12 reset = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_dual_write();
    test_scoreboard();
    test_clear_sweep();
    test_reset_during_sweep();
    test_random();
    test_fpr();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
